// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers BCD digits, decimal points and a binary value from a scanned 4-digit 7-segment bus
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   seg_sel      digit select, active-low, bit0 = rightmost digit
//   seg_led      segments, active-low, [7]=dot, [6:0]=g..a
//   digits       BCD per position, [3:0]=pos0; A blank, B minus, F unknown
//   point        decoded decimal points, active-high
//   value        binary magnitude of the last good frame
//   sign         1 when the last good frame showed a minus
//   frame_valid  one-clk pulse when digits/point (and value unless error) update
//   decode_err   1 when the last frame held an unknown digit
//   link_ok      1 while captures keep arriving before the timeout
module seg_scan_decoder #(
  parameter int STABLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  seg_sel,
  input  logic [7:0]  seg_led,
  output logic [15:0] digits,
  output logic [3:0]  point,
  output logic [13:0] value,
  output logic        sign,
  output logic        frame_valid,
  output logic        decode_err,
  output logic        link_ok
);
  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {COLLECT, CONV, DONE} state_t;

  function automatic logic [3:0] seg_dec(input logic [6:0] p);
    case (p)
      7'h40:   return 4'h0;
      7'h79:   return 4'h1;
      7'h24:   return 4'h2;
      7'h30:   return 4'h3;
      7'h19:   return 4'h4;
      7'h12:   return 4'h5;
      7'h02:   return 4'h6;
      7'h78:   return 4'h7;
      7'h00:   return 4'h8;
      7'h10:   return 4'h9;
      7'h7F:   return 4'hA;
      7'h3F:   return 4'hB;
      default: return 4'hF;
    endcase
  endfunction

  logic [5:0]      sel_s1_q, sel_s2_q, sel_p_q;
  logic [7:0]      led_s1_q, led_s2_q, led_p_q;
  logic [SW-1:0]   stab_q, stab_d;
  logic [TW-1:0]   to_q, to_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0][3:0] wbuf_q, wbuf_d, frm_q, frm_d;
  logic [3:0]      wpt_q, wpt_d, fpt_q, fpt_d;
  logic [13:0]     acc_q, acc_d;
  logic [1:0]      idx_q, idx_d;
  state_t          state_q, state_d;
  logic [15:0]     digits_q, digits_d;
  logic [3:0]      point_q, point_d;
  logic [13:0]     value_q, value_d;
  logic            sign_q, sign_d, fv_q, fv_d, err_q, err_d, link_q, link_d;
  logic            changed, pos_ok, cap, to_hit, take, has_f, has_b;
  logic [1:0]      pos;
  logic [3:0]      cur;

  assign changed = {sel_s2_q, led_s2_q} != {sel_p_q, led_p_q};
  assign pos_ok  = sel_s2_q inside {6'b111110, 6'b111101, 6'b111011, 6'b110111};
  assign pos     = !sel_s2_q[0] ? 2'd0 : !sel_s2_q[1] ? 2'd1 : !sel_s2_q[2] ? 2'd2 : 2'd3;
  // Fires on the single cycle the counter steps to STABLE_CYC-1, so one capture per dwell.
  assign cap     = !changed && stab_q == SW'(STABLE_CYC - 2) && pos_ok;
  assign to_hit  = !cap && to_q == TW'(TIMEOUT_CYC - 1);
  assign take    = state_q == COLLECT && mask_q == 4'hF;
  assign cur     = frm_q[idx_q];

  assign stab_d = changed ? '0 : (stab_q == SW'(STABLE_CYC) ? stab_q : stab_q + SW'(1));
  assign to_d   = cap ? '0 : (to_q == TW'(TIMEOUT_CYC) ? to_q : to_q + TW'(1));
  assign link_d = cap ? 1'b1 : to_hit ? 1'b0 : link_q;
  // A capture landing on the same cycle the frame is taken starts the next frame.
  assign mask_d = to_hit ? 4'h0 : ((take ? 4'h0 : mask_q) | (cap ? 4'b0001 << pos : 4'h0));

  always_comb begin
    wbuf_d = wbuf_q;
    wpt_d  = wpt_q;
    if (cap) begin
      wbuf_d[pos] = seg_dec(led_s2_q[6:0]);
      wpt_d[pos]  = ~led_s2_q[7];
    end
  end

  always_comb begin
    has_f = 1'b0;
    has_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      has_f |= frm_q[i] == 4'hF;
      has_b |= frm_q[i] == 4'hB;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    frm_d    = frm_q;
    fpt_d    = fpt_q;
    digits_d = digits_q;
    point_d  = point_q;
    value_d  = value_q;
    sign_d   = sign_q;
    err_d    = err_q;
    fv_d     = 1'b0;
    case (state_q)
      COLLECT: if (take) begin
        frm_d   = wbuf_q;
        fpt_d   = wpt_q;
        acc_d   = '0;
        idx_d   = 2'd3;
        state_d = CONV;
      end
      CONV: begin
        // Blank, minus and unknown contribute zero; 9999 fits in 14 bits.
        acc_d = acc_q * 14'd10 + {10'd0, cur <= 4'd9 ? cur : 4'd0};
        idx_d = idx_q - 2'd1;
        state_d = idx_q == 2'd0 ? DONE : CONV;
      end
      DONE: begin
        fv_d     = 1'b1;
        digits_d = frm_q;
        point_d  = fpt_q;
        value_d  = has_f ? value_q : acc_q;
        sign_d   = has_f ? sign_q : has_b;
        err_d    = has_f;
        state_d  = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_s1_q <= '1;
      sel_s2_q <= '1;
      sel_p_q  <= '1;
      led_s1_q <= '1;
      led_s2_q <= '1;
      led_p_q  <= '1;
      stab_q   <= '0;
      to_q     <= '0;
      mask_q   <= '0;
      wbuf_q   <= '0;
      wpt_q    <= '0;
      frm_q    <= '0;
      fpt_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      state_q  <= COLLECT;
      digits_q <= 16'hAAAA;
      point_q  <= '0;
      value_q  <= '0;
      sign_q   <= 1'b0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      link_q   <= 1'b0;
    end else begin
      sel_s1_q <= seg_sel;
      sel_s2_q <= sel_s1_q;
      sel_p_q  <= sel_s2_q;
      led_s1_q <= seg_led;
      led_s2_q <= led_s1_q;
      led_p_q  <= led_s2_q;
      stab_q   <= stab_d;
      to_q     <= to_d;
      mask_q   <= mask_d;
      wbuf_q   <= wbuf_d;
      wpt_q    <= wpt_d;
      frm_q    <= frm_d;
      fpt_q    <= fpt_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      digits_q <= digits_d;
      point_q  <= point_d;
      value_q  <= value_d;
      sign_q   <= sign_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      link_q   <= link_d;
    end
  end

  assign digits      = digits_q;
  assign point       = point_q;
  assign value       = value_q;
  assign sign        = sign_q;
  assign frame_valid = fv_q;
  assign decode_err  = err_q;
  assign link_ok     = link_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: scoreboard bench for the scanned 7-segment decoder
module tb_seg_scan_decoder;
  localparam int STABLE_CYC  = 8;
  localparam int TIMEOUT_CYC = 300;
  localparam int D           = 20;
  // Drive -> 2 sync flops -> change seen -> STABLE_CYC-1 counts -> 6 clks to the pulse.
  localparam int LAT         = 2 + 1 + (STABLE_CYC - 1) + 6;

  typedef struct {
    logic [3:0][7:0] pat;
    bit              gl;
    logic [15:0]     digits;
    logic [3:0]      point;
    logic [13:0]     value;
    logic            sign;
    logic            err;
  } vec_t;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  point;
    logic [13:0] value;
    logic        sign;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  seg_sel = '1;
  logic [7:0]  seg_led = '1;
  logic [15:0] digits;
  logic [3:0]  point;
  logic [13:0] value;
  logic        sign, frame_valid, decode_err, link_ok;

  exp_t sb[$];
  exp_t m_e;
  vec_t vt[10];
  int   cyc = 0, n_chk = 0, n_fail = 0, fv_cnt = 0;

  seg_scan_decoder #(.STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .seg_sel(seg_sel), .seg_led(seg_led),
    .digits(digits), .point(point), .value(value), .sign(sign),
    .frame_valid(frame_valid), .decode_err(decode_err), .link_ok(link_ok)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      fv_cnt++;
      if (sb.size() == 0) chk("unexpected_frame_valid", 32'd1, 32'd0);
      else begin
        m_e = sb.pop_front();
        chk("digits", 32'(digits), 32'(m_e.digits));
        chk("point", 32'(point), 32'(m_e.point));
        chk("value", 32'(value), 32'(m_e.value));
        chk("sign", 32'(sign), 32'(m_e.sign));
        chk("decode_err", 32'(decode_err), 32'(m_e.err));
        chk("latency_cyc", 32'(cyc), 32'(m_e.cyc));
      end
    end
  end

  task automatic drive(input int p, input logic [7:0] led, input bit gl, input bit push, input exp_t e);
    logic [5:0] sel;
    sel = ~(6'd1 << p);
    @(negedge clk);
    seg_sel = sel;
    seg_led = led;
    if (push) begin
      e.cyc = cyc + LAT;
      sb.push_back(e);
    end
    for (int i = 1; i < D; i++) begin
      @(negedge clk);
      if (gl) seg_led = (i >= 3 && i < 6) ? 8'h00 : led;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    seg_sel = '1;
    seg_led = '1;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic scan_vec(input vec_t v);
    exp_t e;
    e = '{v.digits, v.point, v.value, v.sign, v.err, 0};
    for (int p = 3; p >= 0; p--) drive(p, v.pat[p], v.gl && p == 1, p == 0, e);
    idle(10);
  endtask

  task automatic check_reset();
    chk("rst_digits", 32'(digits), 32'hAAAA);
    chk("rst_point", 32'(point), 32'd0);
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_sign", 32'(sign), 32'd0);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_decode_err", 32'(decode_err), 32'd0);
    chk("rst_link_ok", 32'(link_ok), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   n;
    vt[0] = '{32'hC0C099A4, 1'b0, 16'h0042, 4'h0, 14'd42,   1'b0, 1'b0};
    vt[1] = '{32'hFFBFF9F8, 1'b0, 16'hAB17, 4'h0, 14'd17,   1'b1, 1'b0};
    vt[2] = '{32'hF924B099, 1'b1, 16'h1234, 4'h4, 14'd1234, 1'b0, 1'b0};
    vt[3] = '{32'h90909090, 1'b0, 16'h9999, 4'h0, 14'd9999, 1'b0, 1'b0};
    vt[4] = '{32'hC0C099A4, 1'b0, 16'h0042, 4'h0, 14'd42,   1'b0, 1'b0};
    vt[5] = '{32'hC08F99A4, 1'b0, 16'h0F42, 4'h0, 14'd42,   1'b0, 1'b1};
    vt[6] = '{32'h808292F8, 1'b0, 16'h8657, 4'h0, 14'd8657, 1'b0, 1'b0};
    vt[7] = '{32'h40404040, 1'b0, 16'h0000, 4'hF, 14'd0,    1'b0, 1'b0};
    vt[8] = '{32'hF9C0C0BF, 1'b0, 16'h100B, 4'h0, 14'd1000, 1'b1, 1'b0};
    vt[9] = '{32'hC0C08FC0, 1'b0, 16'h00F0, 4'h0, 14'd1000, 1'b1, 1'b1};
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    idle(5);
    for (int v = 0; v < 10; v++) scan_vec(vt[v]);
    // Timeout after two captures, then resume the scan where it left off.
    drive(3, 8'hC0, 1'b0, 1'b0, e);
    drive(2, 8'hC0, 1'b0, 1'b0, e);
    chk("link_ok_up", 32'(link_ok), 32'd1);
    n = fv_cnt;
    idle(TIMEOUT_CYC + 20);
    chk("link_ok_timeout", 32'(link_ok), 32'd0);
    chk("hold_digits", 32'(digits), 32'(vt[9].digits));
    chk("hold_value", 32'(value), 32'(vt[9].value));
    chk("timeout_no_frame", 32'(fv_cnt - n), 32'd0);
    e = '{16'h1024, 4'h0, 14'd1024, 1'b0, 1'b0, 0};
    drive(1, 8'hA4, 1'b0, 1'b0, e);
    drive(0, 8'h99, 1'b0, 1'b0, e);
    drive(3, 8'hF9, 1'b0, 1'b0, e);
    drive(2, 8'hC0, 1'b0, 1'b1, e);
    idle(10);
    chk("link_ok_resume", 32'(link_ok), 32'd1);
    // Reset after three captures discards them.
    drive(3, 8'h90, 1'b0, 1'b0, e);
    drive(2, 8'h90, 1'b0, 1'b0, e);
    drive(1, 8'h90, 1'b0, 1'b0, e);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    n = fv_cnt;
    drive(0, 8'hC0, 1'b0, 1'b0, e);
    idle(30);
    chk("reset_no_frame", 32'(fv_cnt - n), 32'd0);
    e = '{16'h1230, 4'h0, 14'd1230, 1'b0, 1'b0, 0};
    drive(3, 8'hF9, 1'b0, 1'b0, e);
    drive(2, 8'hA4, 1'b0, 1'b0, e);
    drive(1, 8'hB0, 1'b0, 1'b1, e);
    idle(20);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
